// File: rtl/parity_pkg.sv
// parity_pkg: shared status bit indices, default parameters and window FSM states.
package parity_pkg;
  localparam int ST_STRETCH = 0;
  localparam int ST_ALARM   = 1;
  localparam int ST_STICKY  = 2;
  localparam int DEF_STRETCH_CYCLES = 8;
  localparam int DEF_WINDOW_CHECKS  = 256;
  localparam int DEF_ALARM_THRESH   = 4;
  localparam int DEF_CNT_W          = 16;
  typedef enum logic [0:0] {IDLE = 1'b0, COUNT = 1'b1} win_state_e;
endpackage

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: holds out high for CYCLES cycles after trig; retrigger reloads.
module pulse_stretcher #(
  parameter int CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic out
);
  localparam int W = $clog2(CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = trig ? W'(CYCLES) : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  assign out = cnt_q != '0;
endmodule

// File: rtl/parity_status_reporter.sv
// parity_status_reporter: turns parity check results into pad status bits and error counts.
module parity_status_reporter
  import parity_pkg::*;
#(
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int WINDOW_CHECKS  = DEF_WINDOW_CHECKS,
  parameter int ALARM_THRESH   = DEF_ALARM_THRESH,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              chk_valid,
  input  logic                              chk_err,
  input  logic                              clr_i,
  output logic [2:0]                        status_o,
  output logic [2:0]                        oeb_o,
  output logic [CNT_W-1:0]                  err_total_o,
  output logic [$clog2(ALARM_THRESH+1)-1:0] win_errs_o
);
  localparam int EW = $clog2(ALARM_THRESH + 1);
  localparam int CW = $clog2(WINDOW_CHECKS + 1);
  win_state_e     state_q, state_d;
  logic [CW-1:0]  chk_q, chk_d, chk_nxt;
  logic [EW-1:0]  werr_q, werr_d, werr_nxt;
  logic [CNT_W-1:0] total_q, total_d;
  logic           alarm_q, alarm_d, sticky_q, sticky_d, stretch, err_ev, close;
  assign err_ev = chk_valid & chk_err;
  pulse_stretcher #(.CYCLES(STRETCH_CYCLES)) u_stretch (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .trig(err_ev),
    .out (stretch)
  );
  // The valid that moves IDLE->COUNT is itself the first check of the window.
  always_comb begin
    chk_nxt  = chk_q + 1'b1;
    close    = chk_valid && chk_nxt == CW'(WINDOW_CHECKS);
    werr_nxt = (err_ev && werr_q != EW'(ALARM_THRESH)) ? werr_q + 1'b1 : werr_q;
    state_d  = clr_i ? IDLE : (chk_valid ? COUNT : state_q);
    chk_d    = (clr_i || close) ? '0 : (chk_valid ? chk_nxt : chk_q);
    werr_d   = (clr_i || close) ? '0 : werr_nxt;
    alarm_d  = clr_i ? 1'b0 : (close ? werr_nxt >= EW'(ALARM_THRESH) : alarm_q);
    sticky_d = ~clr_i & (sticky_q | err_ev);
    total_d  = clr_i ? '0 : ((err_ev && total_q != '1) ? total_q + 1'b1 : total_q);
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      chk_q    <= '0;
      werr_q   <= '0;
      alarm_q  <= 1'b0;
      sticky_q <= 1'b0;
      total_q  <= '0;
    end else begin
      state_q  <= state_d;
      chk_q    <= chk_d;
      werr_q   <= werr_d;
      alarm_q  <= alarm_d;
      sticky_q <= sticky_d;
      total_q  <= total_d;
    end
  end
  always_comb begin
    status_o             = '0;
    status_o[ST_STRETCH] = stretch;
    status_o[ST_ALARM]   = alarm_q;
    status_o[ST_STICKY]  = sticky_q;
  end
  assign oeb_o       = 3'b000;
  assign err_total_o = total_q;
  assign win_errs_o  = werr_q;
endmodule

// File: tb/tb_parity_status_reporter.sv
// tb_parity_status_reporter: directed stimulus with a queued scoreboard checked by a monitor.
module tb_parity_status_reporter;
  typedef struct {
    logic [2:0] st;
    logic [3:0] tot;
    logic [2:0] win;
    string      tag;
  } exp_t;
  logic clk = 0, rst = 1, v = 0, e = 0, c = 0;
  logic [2:0] st, oeb, win;
  logic [3:0] tot;
  int checks = 0, errors = 0;
  exp_t q[$];
  exp_t x;
  always #5 clk = ~clk;
  parity_status_reporter #(
    .STRETCH_CYCLES(8), .WINDOW_CHECKS(16), .ALARM_THRESH(4), .CNT_W(4)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .chk_valid(v), .chk_err(e), .clr_i(c),
    .status_o(st), .oeb_o(oeb), .err_total_o(tot), .win_errs_o(win)
  );
  task automatic cmp(input string name, input string tag, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s/%s got %0h expected %0h at %0t", tag, name, act, req, $time);
    end
  endtask
  task automatic step(input logic r_i, v_i, e_i, c_i, input logic [2:0] s_x,
                      input logic [3:0] t_x, input logic [2:0] w_x, input string tag);
    @(negedge clk);
    rst = r_i; v = v_i; e = e_i; c = c_i;
    q.push_back('{s_x, t_x, w_x, tag});
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      x = q.pop_front();
      cmp("status", x.tag, {5'd0, st}, {5'd0, x.st});
      cmp("total", x.tag, {4'd0, tot}, {4'd0, x.tot});
      cmp("win_errs", x.tag, {5'd0, win}, {5'd0, x.win});
      cmp("oeb", x.tag, {5'd0, oeb}, 8'd0);
    end
  end
  initial begin
    logic er;
    repeat (2) step(1, 1'($urandom), 1'($urandom), 1'($urandom), 3'b000, 0, 0, "reset");
    repeat (3) step(0, 0, 0, 0, 3'b000, 0, 0, "idle");
    step(0, 1, 1, 0, 3'b101, 1, 1, "single_err");
    repeat (7) step(0, 0, 0, 0, 3'b101, 1, 1, "stretch_hold");
    step(0, 0, 0, 0, 3'b100, 1, 1, "stretch_end");
    step(0, 1, 1, 0, 3'b101, 2, 2, "retrig_a");
    repeat (3) step(0, 0, 0, 0, 3'b101, 2, 2, "retrig_gap");
    step(0, 1, 1, 0, 3'b101, 3, 3, "retrig_b");
    repeat (7) step(0, 0, 0, 0, 3'b101, 3, 3, "retrig_hold");
    step(0, 0, 0, 0, 3'b100, 3, 3, "retrig_end");
    step(0, 0, 0, 1, 3'b000, 0, 0, "clr");
    for (int i = 1; i <= 16; i++) begin
      er = i >= 13;
      step(0, 1, er, 0, {er, i == 16, er}, er ? 4'(i - 12) : 4'd0,
           (er && i < 16) ? 3'(i - 12) : 3'd0, "win1_alarm");
    end
    for (int i = 1; i <= 16; i++)
      step(0, 1, i <= 3, 0, {1'b1, i < 16, i <= 10}, 4'(4 + (i < 3 ? i : 3)),
           i == 16 ? 3'd0 : 3'(i < 3 ? i : 3), "win2_quiet");
    step(0, 0, 0, 1, 3'b000, 0, 0, "clr2");
    for (int i = 1; i <= 20; i++)
      step(0, 1, 1, 0, {1'b1, i >= 16, 1'b1}, i < 15 ? 4'(i) : 4'd15,
           i < 16 ? 3'(i < 4 ? i : 4) : (i == 16 ? 3'd0 : 3'(i - 16)), "saturate");
    for (int j = 1; j <= 8; j++) step(0, 0, 0, 0, {2'b11, j < 8}, 15, 4, "sat_hold");
    step(0, 1, 1, 1, 3'b001, 0, 0, "clr_vs_err");
    for (int i = 1; i <= 16; i++) begin
      er = i >= 12 && i <= 15;
      step(0, 1, er, 0, {i >= 12, i == 16, i <= 7 || i >= 12},
           i >= 12 ? (i < 16 ? 4'(i - 11) : 4'd4) : 4'd0,
           er ? 3'(i - 11) : 3'd0, "win_post_clr");
    end
    step(1, 1'($urandom), 1'($urandom), 1'($urandom), 3'b000, 0, 0, "rst_mid");
    step(0, 0, 1, 0, 3'b000, 0, 0, "err_no_valid");
    step(0, 0, 0, 0, 3'b000, 0, 0, "idle_end");
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
